timer_bank: RTL

- Parametrised multi-channel down-counting timer peripheral on the PicoRV memory-mapped bus. Generational successor to the single-channel system tick.
- Each channel has its own prescaler, counter and reload value, and runs in one-shot or auto-reload mode.
- Each channel has a sticky interrupt-pending flag. A single level-sensitive interrupt line is raised while any enabled channel has its flag set.

---
 rtl/timer_bank.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/timer_bank.sv
// ---------------------------------------------------------------------------
// timer_bank
//   Multi-channel down-counting timer on the PicoRV memory-mapped bus.
//   Each channel has a prescaler, a COUNT/RELOAD pair, one-shot or
//   auto-reload operation and a sticky pending flag that feeds a
//   registered interrupt vector and a combined interrupt line.
//
// Ports
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   select   : bus access request
//   wstrb    : byte write strobes, 0 = read
//   addr     : byte address; addr[AW-1:4] channel, addr[3:0] register
//   data_i   : write data
//   ready    : one-cycle access acknowledge
//   data_o   : registered read data, held until the next read
//   irq      : OR over channels of (pending & irq_en), registered
//   irq_vec  : per-channel (pending & irq_en), registered
//
// Per-channel registers (channel base = ch*16)
//   0x0 CTRL   : [0] enable, [1] auto-reload, [2] irq_en,
//                [16+PRESC_WIDTH-1:16] presc
//   0x4 COUNT  : current count
//   0x8 RELOAD : auto-reload value
//   0xC STATUS : [0] running (RO), [1] pending (W1C)
// ---------------------------------------------------------------------------
module timer_bank #(
   parameter int  CHANNELS    = 4,
   parameter int  WIDTH       = 32,
   parameter int  PRESC_WIDTH = 16,
   localparam int AW          = $clog2(CHANNELS) + 4
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                select,
   input  logic [3:0]          wstrb,
   input  logic [AW-1:0]       addr,
   input  logic [31:0]         data_i,
   output logic                ready,
   output logic [31:0]         data_o,
   output logic                irq,
   output logic [CHANNELS-1:0] irq_vec
);

   localparam logic [3:0] OFF_CTRL   = 4'h0;
   localparam logic [3:0] OFF_COUNT  = 4'h4;
   localparam logic [3:0] OFF_RELOAD = 4'h8;
   localparam logic [3:0] OFF_STATUS = 4'hC;

   // Byte-lane merge of a write into the 32-bit image of a register.
   function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  strb);
      f_merge = old_v;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) f_merge[8*b +: 8] = new_v[8*b +: 8];
      end
   endfunction

   // Registered bus outputs
   logic                r_ready;
   logic [31:0]         r_data_o;
   logic                r_irq;
   logic [CHANNELS-1:0] r_irq_vec;

   // Per-channel state
   logic [CHANNELS-1:0]    r_en;
   logic [CHANNELS-1:0]    r_ar;
   logic [CHANNELS-1:0]    r_ie;
   logic [CHANNELS-1:0]    r_pend;
   logic [PRESC_WIDTH-1:0] r_presc  [CHANNELS];
   logic [PRESC_WIDTH-1:0] r_pcnt   [CHANNELS];
   logic [WIDTH-1:0]       r_count  [CHANNELS];
   logic [WIDTH-1:0]       r_reload [CHANNELS];

   // Bus decode
   logic          w_access;
   logic          w_write;
   logic          w_read;
   logic [AW-1:0] w_ch_sel;
   logic [3:0]    w_off;
   logic [31:0]   w_rdata;

   // Per-channel next-state terms
   logic [CHANNELS-1:0]    w_wr_ctrl;
   logic [CHANNELS-1:0]    w_wr_count;
   logic [CHANNELS-1:0]    w_wr_reload;
   logic [CHANNELS-1:0]    w_wr_status;
   logic [CHANNELS-1:0]    w_tick;
   logic [CHANNELS-1:0]    w_term;
   logic [CHANNELS-1:0]    w_en_next;
   logic [CHANNELS-1:0]    w_pend_next;
   logic [CHANNELS-1:0]    w_irq_vec;
   logic [31:0]            w_ctrl_img   [CHANNELS];
   logic [PRESC_WIDTH-1:0] w_presc_new  [CHANNELS];
   logic [WIDTH-1:0]       w_count_new  [CHANNELS];
   logic [WIDTH-1:0]       w_reload_new [CHANNELS];

   assign w_ch_sel = addr >> 4;
   assign w_off    = addr[3:0];
   assign w_access = select & ~r_ready;
   assign w_write  = w_access & (wstrb != 4'b0000);
   assign w_read   = w_access & (wstrb == 4'b0000);

   // A channel index with no matching channel simply selects nothing:
   // reads fall through to 0 and writes strobe no register.
   always_comb begin : p_channel_comb
      // NOTE: every output of this block gets a default before any
      // conditional assignment, so no path can leave a value unassigned
      // and infer a latch.
      w_rdata = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         w_ctrl_img[c]                    = '0;
         w_ctrl_img[c][0]                 = r_en[c];
         w_ctrl_img[c][1]                 = r_ar[c];
         w_ctrl_img[c][2]                 = r_ie[c];
         w_ctrl_img[c][16 +: PRESC_WIDTH] = r_presc[c];

         w_wr_ctrl[c]   = w_write && (w_ch_sel == AW'(c)) && (w_off == OFF_CTRL);
         w_wr_count[c]  = w_write && (w_ch_sel == AW'(c)) && (w_off == OFF_COUNT);
         w_wr_reload[c] = w_write && (w_ch_sel == AW'(c)) && (w_off == OFF_RELOAD);
         w_wr_status[c] = w_write && (w_ch_sel == AW'(c)) && (w_off == OFF_STATUS);

         w_presc_new[c]  = PRESC_WIDTH'(f_merge(w_ctrl_img[c], data_i, wstrb) >> 16);
         w_count_new[c]  = WIDTH'(f_merge(32'(r_count[c]), data_i, wstrb));
         w_reload_new[c] = WIDTH'(f_merge(32'(r_reload[c]), data_i, wstrb));

         w_tick[c] = r_en[c] && (r_pcnt[c] == r_presc[c]);
         w_term[c] = w_tick[c] && (r_count[c] == '0);

         // Hardware one-shot stop, overridden by a bus write to enable.
         w_en_next[c] = r_en[c];
         if (w_term[c] && !r_ar[c])          w_en_next[c] = 1'b0;
         if (w_wr_ctrl[c] && wstrb[0])       w_en_next[c] = data_i[0];

         // W1C of pending, overridden by a terminal event in the same cycle.
         w_pend_next[c] = r_pend[c];
         if (w_wr_status[c] && wstrb[0] && data_i[1]) w_pend_next[c] = 1'b0;
         if (w_term[c])                               w_pend_next[c] = 1'b1;

         w_irq_vec[c] = r_pend[c] & r_ie[c];

         if (w_ch_sel == AW'(c)) begin
            case (w_off)
               OFF_CTRL:   w_rdata = w_ctrl_img[c];
               OFF_COUNT:  w_rdata = 32'(r_count[c]);
               OFF_RELOAD: w_rdata = 32'(r_reload[c]);
               OFF_STATUS: w_rdata = {30'b0, r_pend[c], r_en[c]};
               default:    w_rdata = '0;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin : p_regs
      // NOTE: state is updated only with non-blocking assignments so every
      // register samples the pre-edge value of every other register.
      if (!reset_n) begin
         r_ready   <= 1'b0;
         r_data_o  <= '0;
         r_irq     <= 1'b0;
         r_irq_vec <= '0;
         r_en      <= '0;
         r_ar      <= '0;
         r_ie      <= '0;
         r_pend    <= '0;
         // NOTE: these per-channel arrays are individual flops rather than a
         // RAM, so they can and must be cleared by the asynchronous reset.
         for (int c = 0; c < CHANNELS; c++) begin
            r_presc[c]  <= '0;
            r_pcnt[c]   <= '0;
            r_count[c]  <= '0;
            r_reload[c] <= '0;
         end
      end else begin
         r_ready   <= w_access;
         if (w_read) r_data_o <= w_rdata;
         r_irq_vec <= w_irq_vec;
         r_irq     <= |w_irq_vec;
         r_en      <= w_en_next;
         r_pend    <= w_pend_next;

         for (int c = 0; c < CHANNELS; c++) begin
            if (w_wr_ctrl[c]) begin
               if (wstrb[0]) begin
                  r_ar[c] <= data_i[1];
                  r_ie[c] <= data_i[2];
               end
               r_presc[c] <= w_presc_new[c];
            end

            // A CTRL write restarts the prescale interval.
            if (w_wr_ctrl[c] || !r_en[c] || w_tick[c]) begin
               r_pcnt[c] <= '0;
            end else begin
               r_pcnt[c] <= r_pcnt[c] + PRESC_WIDTH'(1);
            end

            // A bus write to COUNT takes precedence over the tick.
            if (w_wr_count[c]) begin
               r_count[c] <= w_count_new[c];
            end else if (w_tick[c]) begin
               if (r_count[c] != '0) begin
                  r_count[c] <= r_count[c] - WIDTH'(1);
               end else if (r_ar[c]) begin
                  r_count[c] <= r_reload[c];
               end
            end

            if (w_wr_reload[c]) r_reload[c] <= w_reload_new[c];
         end
      end
   end

   assign ready   = r_ready;
   assign data_o  = r_data_o;
   assign irq     = r_irq;
   assign irq_vec = r_irq_vec;

endmodule
